// File: rtl/rand_range.sv
// rand_range: maps a stream of raw random words to uniform integers in
// [0, bound) by power-of-two mask-and-reject, so there is no modulo bias.
// Accepted results are buffered in a small FIFO behind a valid/ready handshake.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   bound        exclusive upper limit, captured when bound_load=1
//   bound_load   latch bound, recompute mask, flush candidate/FIFO/counter
//   in_valid     raw word available          in_ready  raw word accepted
//   in_data      raw random word
//   out_valid    FIFO head holds a result    out_ready consumer pops head
//   out_data     result in [0, bound)
//   level        FIFO occupancy
//   reject_cnt   saturating count of rejected candidates
module rand_range #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           bound,
  input  logic                       bound_load,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           reject_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_bound;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cand;
  logic             r_cand_vld;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [CNT_W-1:0] r_rej;
  logic [WIDTH-1:0] r_hold;

  logic [WIDTH-1:0] w_smear;
  logic [LW:0]      w_occ;
  logic             w_accept;
  logic             w_push;
  logic             w_drop;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;

  // Smallest all-ones mask covering bound-1: OR-smear every bit downward.
  always_comb begin
    w_smear = bound - WIDTH'(1);
    for (int s = 1; s < WIDTH; s = s * 2)
      w_smear = w_smear | (w_smear >> s);
  end

  // Reserve a FIFO slot for the in-flight candidate so a push never overflows.
  assign w_occ     = {1'b0, r_level} + (LW+1)'(r_cand_vld);
  assign in_ready  = (r_bound != '0) && (w_occ < (LW+1)'(DEPTH));
  assign w_accept  = in_valid && in_ready;

  assign w_push    = r_cand_vld && (r_cand < r_bound);
  assign w_drop    = r_cand_vld && !(r_cand < r_bound);

  assign out_valid = (r_level != '0);
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rptr];

  // Head when valid; otherwise the last head shown (0 after reset/flush).
  assign out_data   = out_valid ? w_head : r_hold;
  assign level      = r_level;
  assign reject_cnt = r_rej;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bound    <= '0;
      r_mask     <= '0;
      r_cand     <= '0;
      r_cand_vld <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rej      <= '0;
      r_hold     <= '0;
    end else if (bound_load) begin
      r_bound    <= bound;
      r_mask     <= w_smear;
      r_cand_vld <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_rej      <= '0;
      r_hold     <= '0;
    end else begin
      r_cand_vld <= w_accept;
      if (w_accept)
        r_cand <= in_data & r_mask;
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      if (out_valid)
        r_hold <= w_head;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop && (r_rej != {CNT_W{1'b1}}))
        r_rej <= r_rej + CNT_W'(1);
    end
  end

  // Storage needs no reset: entries are only visible while level covers them.
  always_ff @(posedge clk) begin
    if (!rst && !bound_load && w_push)
      r_mem[r_wptr] <= r_cand;
  end

endmodule

// File: tb/tb_rand_range.sv
module tb_rand_range;

  localparam int W = 32;
  localparam int D = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  bound;
  logic          bound_load;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [$clog2(D):0] level;
  logic [CW-1:0] reject_cnt;

  rand_range #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bound(bound), .bound_load(bound_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_bound = '0;
  logic [W-1:0] m_mask = '0;
  int           m_rej = 0;
  localparam int REJ_MAX = (1 << CW) - 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mask = next power of two at or above bound, minus one.
  function automatic logic [W-1:0] mask_of(input logic [W-1:0] b);
    logic [W:0] p;
    p = 1;
    while (p < {1'b0, b}) p = p << 1;
    return W'(p - 1);
  endfunction

  // Stimulus-side model: on every accepted word, predict its fate.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_bound = '0; m_mask = '0; m_rej = 0;
    end else if (bound_load) begin
      exp_q.delete();
      m_bound = bound; m_mask = mask_of(bound); m_rej = 0;
    end else begin
      if (m_bound == '0) check("disabled_in_ready", {31'b0, in_ready}, 32'd0);
      if (in_valid && in_ready) begin
        if ((in_data & m_mask) < m_bound) exp_q.push_back(in_data & m_mask);
        else if (m_rej < REJ_MAX) m_rej++;
      end
    end
  end

  // Monitor: compare every popped head against the scoreboard.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && !bound_load && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: got %h expected none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] b);
    bound = b; bound_load = 1'b1;
    @(posedge clk); #1;
    bound_load = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        n_chk++; n_fail++;
        $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_rej(input string name);
    check(name, {28'b0, reject_cnt}, 32'(m_rej));
  endtask

  task automatic chk_sb_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bound = '0; bound_load = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    idle(3);
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_reject", {28'b0, reject_cnt}, 32'd0);

    // bound=6: words 5,7,FFFFFFFE,12345673 -> 5, 3; two rejects
    out_ready = 1'b1;
    load(32'd6);
    send(32'h5);
    check("lat_edge_k", {31'b0, out_valid}, 32'd0);
    idle(1);
    check("lat_edge_k1_valid", {31'b0, out_valid}, 32'd1);
    check("lat_edge_k1_data", out_data, 32'd5);
    send(32'h7); send(32'hFFFF_FFFE); send(32'h1234_5673);
    idle(4);
    check("b6_reject", {28'b0, reject_cnt}, 32'd2);
    chk_rej("b6_reject_model");
    check("b6_hold_data", out_data, 32'd3);
    chk_sb_empty("b6_sb_empty");

    // bound=1: every word maps to 0
    load(32'd1);
    for (int i = 0; i < 10; i++) send($urandom);
    idle(4);
    check("b1_reject", {28'b0, reject_cnt}, 32'd0);
    chk_sb_empty("b1_sb_empty");

    // bound=2^31
    load(32'h8000_0000);
    send(32'hFFFF_FFFF); send(32'h8000_0001);
    idle(4);
    check("b31_reject", {28'b0, reject_cnt}, 32'd0);
    chk_sb_empty("b31_sb_empty");

    // bound=4, consumer stalled: fill, back-pressure, then drain in order
    load(32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i));
    in_valid = 1'b1; in_data = 32'd0;
    idle(3);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_level", {29'b0, level}, 32'd4);
    check("full_out_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    send(32'd0);
    idle(5);
    check("drain_level", {29'b0, level}, 32'd0);
    chk_sb_empty("drain_sb_empty");

    // Flush: 2 entries + candidate in flight, then load bound=10
    out_ready = 1'b0;
    send(32'd1); send(32'd2); send(32'd3);
    check("pre_flush_level", {29'b0, level}, 32'd2);
    load(32'd10);
    check("flush_level", {29'b0, level}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_reject", {28'b0, reject_cnt}, 32'd0);
    check("flush_out_data", out_data, 32'd0);
    out_ready = 1'b1;
    idle(3);
    check("flush_no_stale", {31'b0, out_valid}, 32'd0);
    send(32'hFFFF_FFFF); send(32'h0000_0009);
    idle(4);
    check("b10_reject", {28'b0, reject_cnt}, 32'd1);
    chk_sb_empty("b10_sb_empty");

    // Reset while full with in_valid held
    load(32'd4);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(i));
    in_valid = 1'b1; in_data = 32'd2;
    idle(2);
    check("prerst_level", {29'b0, level}, 32'd4);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mrst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mrst_out_data", out_data, 32'd0);
    check("mrst_level", {29'b0, level}, 32'd0);
    check("mrst_reject", {28'b0, reject_cnt}, 32'd0);
    idle(3);
    check("mrst_in_ready_hold", {31'b0, in_ready}, 32'd0);
    load(32'd0);
    idle(3);
    check("b0_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Randomized traffic over several bounds (bound=5 drives saturation)
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] b;
      case (k)
        0: b = 32'd5;
        1: b = 32'($urandom_range(1, 40));
        2: b = $urandom | 32'h1;
        default: b = 32'($urandom_range(1, 1000));
      endcase
      load(b);
      for (int c = 0; c < 300; c++) begin
        in_valid  = ($urandom % 4) != 0;
        in_data   = $urandom;
        out_ready = ($urandom % 3) != 0;
        idle(1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      idle(8);
      chk_rej("rand_reject");
      chk_sb_empty("rand_sb_empty");
      check("rand_level", {29'b0, level}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rand_range.md
Name: rand_range

Overview:
- Downstream consumer of the 32-bit LCG output stream.
- Maps raw random words to uniformly distributed integers in [0, bound) using power-of-two mask-and-reject, so there is no modulo bias.
- Buffers accepted results in a small FIFO behind a valid/ready handshake, so game/test logic can draw values at its own pace.
- Upstream presents words as a valid/ready stream; a wrapper holds in_valid high and advances the generator on each accepted transfer.

Parameters:
- WIDTH, 32: data width of input words, bound and output.
- DEPTH, 4: output FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the saturating reject counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- bound  in  WIDTH  exclusive upper limit; sampled only when bound_load=1.
- bound_load  in  1  latch bound, recompute mask, flush pipeline and FIFO.
- in_valid  in  1  raw word available.
- in_ready  out  1  block accepts a raw word this cycle.
- in_data  in  WIDTH  raw random word.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  WIDTH  result in [0, bound).
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- reject_cnt  out  CNT_W  number of rejected candidates, saturating.

Behaviour:
- Reset (rst=1 at the edge):
  - bound_q=0, mask_q=0, cand_valid=0, FIFO empty.
  - Outputs: in_ready=0, out_valid=0, out_data=0, level=0, reject_cnt=0.
  - Reset mid-operation discards the candidate and all FIFO contents.
- Bound load:
  - bound_load=1 at an edge sets bound_q=bound.
  - It sets mask_q = (bound-1) with every bit below its MSB set (OR-smear). Examples: bound=6 gives 7; bound=1 gives 0; bound=2^31 gives 0x7FFFFFFF.
  - The same edge flushes the FIFO, clears cand_valid and clears reject_cnt.
  - bound_load takes priority over any push, pop or accept on that edge.
- Disabled state:
  - bound_q==0 means disabled: in_ready=0 and no outputs are produced.
  - This is the state after reset; it also follows bound_load with bound=0.
- in_ready:
  - in_ready = (bound_q!=0) && (level + cand_valid < DEPTH).
  - Registered-state function only; there is no combinational path from out_ready or in_valid.
- Stage 1 (accept):
  - On in_valid && in_ready at edge k: cand_q = in_data & mask_q, cand_valid=1.
  - Otherwise cand_valid=0 (cand_valid is single-cycle per accepted word).
- Stage 2 (test), at edge k+1:
  - If cand_q < bound_q, push cand_q into the FIFO.
  - Otherwise drop it and increment reject_cnt. The counter saturates at 2^CNT_W-1 and never wraps.
- Latency:
  - An accepted word is visible on out_data/out_valid after edge k+1, i.e. 2 edges from acceptance.
  - Throughput is 1 word per cycle while the FIFO is not full.
- FIFO:
  - out_data = head entry; out_valid = (level!=0).
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop leaves level unchanged and preserves order.
  - Pop when empty is ignored.
  - Push can never overflow because in_ready reserves a slot for every in-flight candidate.
  - Read/write pointers wrap modulo DEPTH.
  - out_data holds its last value while out_valid=0 (0 after reset or flush).
- Arithmetic: all comparisons are unsigned WIDTH-bit. Acceptance probability per word is at least 1/2.
- bound=1: mask 0, every word yields 0, no rejects.

Test Plan:
- Reset, then bound_load with bound=6 → mask_q=7. Send words 0x00000005, 0x00000007, 0xFFFFFFFE, 0x12345673 with out_ready=1 → outputs 5 then 3 only; reject_cnt=2; first out_valid 2 edges after the first accept.
- bound=1, send 10 random words → ten outputs all 0, reject_cnt=0.
- bound=0x80000000, send 0xFFFFFFFF and 0x80000001 → outputs 0x7FFFFFFF and 0x00000001, no rejects.
- bound=4, out_ready=0, stream 0,1,2,3,0 → in_ready falls once level+cand_valid=4; level=4. Raise out_ready → 0,1,2,3 popped in order, then the fifth word accepted and output.
- FIFO holding 2 entries with a candidate in flight, then pulse bound_load with bound=10 → next cycle level=0, out_valid=0, reject_cnt=0, mask_q=15; nothing from the old range ever appears.
- Assert rst while the FIFO is full and in_valid=1 → next cycle all outputs at reset values and in_ready=0 until a nonzero bound is loaded. Then bound_load with bound=0 → in_ready stays 0.
